// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS32 control path:
// opcode/funct encodings, ALU control codes, ALUOp selector and FSM states.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_BNE     = 4'd12
    } state_e;

    // True for the R-type funct codes the datapath can execute.
    function automatic logic funct_is_legal(input logic [5:0] funct);
        case (funct)
            FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: turns the FSM's coarse ALUOp request (plus Funct for R-type)
// into the 3-bit ALU_control code.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // Unknown funct codes fall back to add; the FSM never reaches EXECUTE with one.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS32 control FSM (lw, sw, R-type, beq, addi, j).
// Optional feature macro: MIPS_BNE_EN adds a bne path through state 12.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               zero_sig,
    output logic [2:0]         ALU_control,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic [1:0]         PCSrc,
    output logic               PCEn,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] state_out
);

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    pc_write, branch_eq, branch_ne;
    logic    mem_write, ir_write, reg_write, illegal;

    // Next-state selection and Moore decode of the current state.
    always_comb begin
        state_d   = S_FETCH;
        alu_op    = ALUOP_ADD;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        IorD      = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        PCSrc     = 2'b00;
        pc_write  = 1'b0;
        branch_eq = 1'b0;
        branch_ne = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                ALUSrcB  = 2'b01;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_is_legal(Funct)) begin
                            state_d = S_EXECUTE;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
`ifdef MIPS_BNE_EN
                    OP_BNE:  state_d = S_BNE;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (Op == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                MemtoReg  = 1'b1;
            end
            S_MEMWR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                RegDst    = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b1;
                alu_op    = ALUOP_SUB;
                PCSrc     = 2'b01;
                branch_eq = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
`ifdef MIPS_BNE_EN
            S_BNE: begin
                ALUSrcA   = 1'b1;
                alu_op    = ALUOP_SUB;
                PCSrc     = 2'b01;
                branch_ne = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (Funct),
        .alu_control (ALU_control)
    );

    // Write enables are masked while reset is held so no partial writes leak out.
    assign MemWrite      = mem_write & ~reset;
    assign IRWrite       = ir_write & ~reset;
    assign RegWrite      = reg_write & ~reset;
    assign illegal_instr = illegal & ~reset;
    assign PCEn          = (pc_write | (branch_eq & zero_sig) | (branch_ne & ~zero_sig)) & ~reset;
    assign state_out     = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: cycle-by-cycle vector table plus
// hand-written reset-abort and latency sequences.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] alu;
        logic       srcA;
        logic [1:0] srcB;
        logic       iorD;
        logic       memW;
        logic       irW;
        logic       regDst;
        logic       memToReg;
        logic       regW;
        logic [1:0] pcSrc;
        logic       pcEn;
        logic       ill;
    } outs_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        outs_t      exp;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zeroSig;
    logic [2:0] aluControl;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       iorD;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic [1:0] pcSrc;
    logic       pcEn;
    logic       illegalInstr;
    logic [3:0] stateOut;

    int   checkCount = 0;
    int   passCount  = 0;
    vec_t vecs[$];

    mips_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .Op            (op),
        .Funct         (funct),
        .zero_sig      (zeroSig),
        .ALU_control   (aluControl),
        .ALUSrcA       (aluSrcA),
        .ALUSrcB       (aluSrcB),
        .IorD          (iorD),
        .MemWrite      (memWrite),
        .IRWrite       (irWrite),
        .RegDst        (regDst),
        .MemtoReg      (memToReg),
        .RegWrite      (regWrite),
        .PCSrc         (pcSrc),
        .PCEn          (pcEn),
        .illegal_instr (illegalInstr),
        .state_out     (stateOut)
    );

    // 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t mk(input logic [3:0] st, input logic [2:0] alu,
                                 input logic srcA, input logic [1:0] srcB,
                                 input logic iorDv, input logic memW, input logic irW,
                                 input logic rDst, input logic m2r, input logic regW,
                                 input logic [1:0] pcS, input logic pcE, input logic ill);
        outs_t o;
        o.st = st; o.alu = alu; o.srcA = srcA; o.srcB = srcB;
        o.iorD = iorDv; o.memW = memW; o.irW = irW; o.regDst = rDst;
        o.memToReg = m2r; o.regW = regW; o.pcSrc = pcS; o.pcEn = pcE; o.ill = ill;
        return o;
    endfunction

    function automatic outs_t sampleDut();
        return mk(stateOut, aluControl, aluSrcA, aluSrcB, iorD, memWrite, irWrite,
                  regDst, memToReg, regWrite, pcSrc, pcEn, illegalInstr);
    endfunction

    task automatic addVec(input string name, input logic rst, input logic [5:0] o,
                          input logic [5:0] f, input logic z, input outs_t exp);
        vec_t v;
        v.name = name; v.rst = rst; v.op = o; v.funct = f; v.zero = z; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic rst, input logic [5:0] o,
                                 input logic [5:0] f, input logic z);
        reset   = rst;
        op      = o;
        funct   = f;
        zeroSig = z;
    endtask

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        act = sampleDut();
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %b expected %b (state got %0d expected %0d)",
                     name, act, exp, act.st, exp.st);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one instruction from FETCH and counts edges until FETCH again.
    task automatic measureLatency(input string name, input logic [5:0] o,
                                  input logic [5:0] f, input int expCycles);
        int cycles;
        applyStimulus(1'b0, o, f, 1'b0);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (stateOut != 4'd0 && cycles < 20);
        checkValue(name, cycles, expCycles);
    endtask

    initial begin
        outs_t fR, fS, dS, dI, ma, mr, mwb, mwr, awb, br1, br0, aix, aiwb, jS, bne1;

        fR   = mk(4'd0,  3'b010, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        fS   = mk(4'd0,  3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0);
        dS   = mk(4'd1,  3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        dI   = mk(4'd1,  3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        ma   = mk(4'd2,  3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        mr   = mk(4'd3,  3'b010, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        mwb  = mk(4'd4,  3'b010, 0, 2'b00, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0);
        mwr  = mk(4'd5,  3'b010, 0, 2'b00, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0);
        awb  = mk(4'd7,  3'b010, 0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0);
        br1  = mk(4'd8,  3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0);
        br0  = mk(4'd8,  3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        aix  = mk(4'd9,  3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        aiwb = mk(4'd10, 3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
        jS   = mk(4'd11, 3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0);
        bne1 = mk(4'd12, 3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0);

        addVec("reset_hold",   1, 6'b100011, 6'b000000, 0, fR);
        addVec("lw_fetch",     0, 6'b100011, 6'b000000, 0, fS);
        addVec("lw_decode",    0, 6'b100011, 6'b000000, 0, dS);
        addVec("lw_memadr",    0, 6'b100011, 6'b000000, 0, ma);
        addVec("lw_memrd",     0, 6'b100011, 6'b000000, 0, mr);
        addVec("lw_memwb",     0, 6'b100011, 6'b000000, 0, mwb);
        addVec("sw_fetch",     0, 6'b101011, 6'b000000, 0, fS);
        addVec("sw_decode",    0, 6'b101011, 6'b000000, 0, dS);
        addVec("sw_memadr",    0, 6'b101011, 6'b000000, 0, ma);
        addVec("sw_memwr",     0, 6'b101011, 6'b000000, 0, mwr);
        addVec("add_fetch",    0, 6'b000000, 6'b100000, 1, fS);
        addVec("add_decode",   0, 6'b000000, 6'b100000, 1, dS);
        addVec("add_exec",     0, 6'b000000, 6'b100000, 1,
               mk(4'd6, 3'b010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        addVec("add_wb",       0, 6'b000000, 6'b100000, 1, awb);
        addVec("sub_fetch",    0, 6'b000000, 6'b100010, 0, fS);
        addVec("sub_decode",   0, 6'b000000, 6'b100010, 0, dS);
        addVec("sub_exec",     0, 6'b000000, 6'b100010, 0,
               mk(4'd6, 3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        addVec("sub_wb",       0, 6'b000000, 6'b100010, 0, awb);
        addVec("and_fetch",    0, 6'b000000, 6'b100100, 0, fS);
        addVec("and_decode",   0, 6'b000000, 6'b100100, 0, dS);
        addVec("and_exec",     0, 6'b000000, 6'b100100, 0,
               mk(4'd6, 3'b000, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        addVec("and_wb",       0, 6'b000000, 6'b100100, 0, awb);
        addVec("or_fetch",     0, 6'b000000, 6'b100101, 0, fS);
        addVec("or_decode",    0, 6'b000000, 6'b100101, 0, dS);
        addVec("or_exec",      0, 6'b000000, 6'b100101, 0,
               mk(4'd6, 3'b001, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        addVec("or_wb",        0, 6'b000000, 6'b100101, 0, awb);
        addVec("slt_fetch",    0, 6'b000000, 6'b101010, 0, fS);
        addVec("slt_decode",   0, 6'b000000, 6'b101010, 0, dS);
        addVec("slt_exec",     0, 6'b000000, 6'b101010, 0,
               mk(4'd6, 3'b111, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        addVec("slt_wb",       0, 6'b000000, 6'b101010, 0, awb);
        addVec("beq1_fetch",   0, 6'b000100, 6'b000000, 1, fS);
        addVec("beq1_decode",  0, 6'b000100, 6'b000000, 1, dS);
        addVec("beq1_branch",  0, 6'b000100, 6'b000000, 1, br1);
        addVec("beq0_fetch",   0, 6'b000100, 6'b000000, 0, fS);
        addVec("beq0_decode",  0, 6'b000100, 6'b000000, 0, dS);
        addVec("beq0_branch",  0, 6'b000100, 6'b000000, 0, br0);
        addVec("addi_fetch",   0, 6'b001000, 6'b000000, 0, fS);
        addVec("addi_decode",  0, 6'b001000, 6'b000000, 0, dS);
        addVec("addi_ex",      0, 6'b001000, 6'b000000, 0, aix);
        addVec("addi_wb",      0, 6'b001000, 6'b000000, 0, aiwb);
        addVec("badfn_fetch",  0, 6'b000000, 6'b000000, 0, fS);
        addVec("badfn_decode", 0, 6'b000000, 6'b000000, 0, dI);
        addVec("badop_fetch",  0, 6'b111111, 6'b100000, 0, fS);
        addVec("badop_decode", 0, 6'b111111, 6'b100000, 0, dI);
        addVec("bne_fetch",    0, 6'b000101, 6'b000000, 0, fS);
`ifdef MIPS_BNE_EN
        addVec("bne_decode",   0, 6'b000101, 6'b000000, 0, dS);
        addVec("bne_state",    0, 6'b000101, 6'b000000, 0, bne1);
`else
        addVec("bne_illegal",  0, 6'b000101, 6'b000000, 0, dI);
`endif
        addVec("j_fetch",      0, 6'b000010, 6'b000000, 1, fS);
        addVec("j_decode",     0, 6'b000010, 6'b000000, 1, dS);
        addVec("j_jump",       0, 6'b000010, 6'b000000, 1, jS);

        applyStimulus(1'b1, 6'b000000, 6'b000000, 1'b0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].zero);
            @(negedge clk);
            checkOutput(vecs[i].name, vecs[i].exp);
            @(posedge clk); #1;
        end

        // sw aborted by reset during MEMADR: no write, back in FETCH.
        applyStimulus(1'b0, 6'b101011, 6'b000000, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkValue("swrst_memadr_state", int'(stateOut), 2);
        checkValue("swrst_memadr_memw", int'(memWrite), 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkValue("swrst_after_state", int'(stateOut), 0);
        checkValue("swrst_after_memw", int'(memWrite), 0);
        reset = 1'b0;

        // sw with reset held in MEMWR: MemWrite masked, IorD still decoded.
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkValue("swrst_memwr_state", int'(stateOut), 5);
        checkValue("swrst_memwr_memw", int'(memWrite), 0);
        checkValue("swrst_memwr_iord", int'(iorD), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkValue("swrst2_after_state", int'(stateOut), 0);
        checkValue("swrst2_after_irw", int'(irWrite), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        measureLatency("lat_lw",   6'b100011, 6'b000000, 5);
        measureLatency("lat_sw",   6'b101011, 6'b000000, 4);
        measureLatency("lat_rtype", 6'b000000, 6'b100000, 4);
        measureLatency("lat_addi", 6'b001000, 6'b000000, 4);
        measureLatency("lat_beq",  6'b000100, 6'b000000, 3);
        measureLatency("lat_j",    6'b000010, 6'b000000, 3);
        measureLatency("lat_illegal", 6'b111111, 6'b000000, 2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle MIPS32 control FSM. It is the driving end of the ALU interface: it generates ALU_control and the datapath mux selects and enables, and it consumes zero_sig for branches. Op and Funct come from the instruction register and are stable from DECODE until the next FETCH. Supported instructions: lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.

Parameters:
STATE_W, 4, width of the state register (12 states).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
Op  input  6  instruction opcode [31:26]
Funct  input  6  R-type funct [5:0]
zero_sig  input  1  ALU zero flag, sampled in BRANCH
ALU_control  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
ALUSrcA  output  1  0 = PC, 1 = register A
ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register load
RegDst  output  1  write register select: 0 = rt, 1 = rd
MemtoReg  output  1  write-back data select: 1 = memory data
RegWrite  output  1  register file write enable
PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
PCEn  output  1  PC load
illegal_instr  output  1  one-cycle flag: unsupported Op or Funct
state_out  output  STATE_W  current state, for debug

Behaviour:
- Reset:
  - reset high at a clock edge loads state = FETCH.
  - While reset is high, MemWrite, IRWrite, RegWrite, PCEn and illegal_instr are forced to 0 combinationally.
  - Reset mid-instruction abandons the instruction; no partial writes occur after the reset edge.
- Outputs are Moore, decoded from the state. Exception: PCEn = PCWrite | (Branch & zero_sig).
- Output defaults in every state: all enables 0, selects 0, ALU_control = 010.
- State encodings and assertions:
  - FETCH (0): IRWrite, PCWrite, ALUSrcB=01, add; next DECODE.
  - DECODE (1): ALUSrcB=11, add (branch target). Next state by Op:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - anything else -> FETCH, with illegal_instr=1.
    - Op=000000 with a Funct outside {100000, 100010, 100100, 100101, 101010} is also illegal -> FETCH.
  - MEMADR (2): ALUSrcA=1, ALUSrcB=10, add; lw -> MEMRD, sw -> MEMWR.
  - MEMRD (3): IorD=1; next MEMWB.
  - MEMWB (4): RegWrite, MemtoReg=1, RegDst=0; next FETCH.
  - MEMWR (5): IorD=1, MemWrite; next FETCH.
  - EXECUTE (6): ALUSrcA=1, ALUSrcB=00, ALU_control from Funct (add 010, sub 110, and 000, or 001, slt 111); next ALUWB.
  - ALUWB (7): RegWrite, RegDst=1, MemtoReg=0; next FETCH.
  - BRANCH (8): ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch=1; next FETCH.
  - ADDIEX (9): ALUSrcA=1, ALUSrcB=10, add; next ADDIWB.
  - ADDIWB (10): RegWrite, RegDst=0, MemtoReg=0; next FETCH.
  - JUMP (11): PCSrc=10, PCWrite; next FETCH.
- Unreachable encodings 12-15: all outputs at defaults; next FETCH.
- Latency in cycles: lw 5; sw, R-type, addi 4; beq, j 3; illegal instruction 2.
- zero_sig affects outputs only in BRANCH (in BRANCH or, with MIPS_BNE_EN, BNE).

Optional Feature:
MIPS_BNE_EN:
- Defined: Op 000101 in DECODE -> BNE state (12). BNE has the same outputs as BRANCH, but PCEn = ~zero_sig; next FETCH.
- Undefined: Op 000101 is illegal (illegal_instr=1, return to FETCH), and state 12 is unreachable.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct constants
  - ALU_control codes (add, sub, anding, oring, SLT)
  - state encodings
  - ALUOp enum (00 add, 01 sub, 10 use Funct)
- Sub-module alu_decoder: combinational (ALUOp, Funct) -> ALU_control. The FSM drives ALUOp, never ALU_control directly.

Test Plan:
- reset=1 for 2 cycles, then release -> state_out=0, IRWrite=1, PCEn=1, ALUSrcB=01, ALU_control=010 in the first post-reset cycle.
- Op=100011 (lw) -> states 0,1,2,3,4; RegWrite=1 with MemtoReg=1 only in state 4; MemWrite never asserted.
- Op=000100 with zero_sig=1 in BRANCH -> PCEn=1, PCSrc=01, ALU_control=110; repeat with zero_sig=0 -> PCEn=0.
- Op=000000, Funct=101010 -> ALU_control=111 in EXECUTE, then RegWrite=1, RegDst=1 in ALUWB; Funct=000000 -> illegal_instr=1 in DECODE and the next state is FETCH.
- sw, with reset asserted during MEMADR -> MemWrite stays 0 and state_out=0 after the edge.
- Op=000101: with MIPS_BNE_EN and zero_sig=0 -> PCEn=1 in state 12; without the macro -> illegal_instr=1.
